sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
Parametrised single-clock FIFO, next generation of the team's synchronous FIFO. It generalises width and depth and adds programmable almost-full/almost-empty thresholds, an occupancy output and sticky error flags. A FWFT parameter selects either a standard registered-read mode or a first-word-fall-through mode. It sits between stream producers and consumers as the standard buffering primitive.

Parameters:
DATA_W, 16, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
ADDR_W, $clog2(DEPTH), derived pointer width; not overridden
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  reset, synchronous, active-low
wr_en  in  1  write request
data_in  in  DATA_W  write data
rd_en  in  1  read request (pop)
af_thresh  in  ADDR_W+1  almost-full threshold
ae_thresh  in  ADDR_W+1  almost-empty threshold
err_clr  in  1  clears sticky error flags
data_out  out  DATA_W  read data
valid  out  1  data_out qualifier
wr_ack  out  1  registered: previous-cycle write accepted
overflow  out  1  registered: previous-cycle write rejected
underflow  out  1  registered: previous-cycle read rejected
full  out  1  count == DEPTH
empty  out  1  count == 0
almostfull  out  1  count >= af_thresh
almostempty  out  1  count <= ae_thresh
count  out  ADDR_W+1  current occupancy, 0..DEPTH
ovf_sticky  out  1  latched overflow
unf_sticky  out  1  latched underflow

Behaviour:
- Reset (rst_n low at posedge): wr_ptr, rd_ptr and count go to 0. wr_ack, overflow, underflow, valid and both sticky flags go to 0. data_out goes to 0. Memory contents are not reset. Reset takes priority over every other input, including mid-burst operation.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc). A write when full is accepted only together with a read.
- Both requests while empty: the write is accepted, the read is rejected and flags underflow.
- Next count: count +1 when wr_acc && !rd_acc; -1 when rd_acc && !wr_acc; unchanged otherwise.
- Pointers advance by 1 on their own accept and wrap from DEPTH-1 to 0 naturally, since ADDR_W bits hold exactly DEPTH values.
- wr_ack <= wr_acc; overflow <= wr_en && !wr_acc; underflow <= rd_en && !rd_acc. Each is a one-cycle registered pulse.
- ovf_sticky sets when overflow is driven high and holds until err_clr. unf_sticky behaves the same way for underflow. If set and err_clr coincide, set wins.
- full, empty, almostfull and almostempty are combinational from the registered count.
- After reset, empty = 1, full = 0, and almostempty = 1 for any ae_thresh.
- Thresholds are live inputs, not latched. An af_thresh value above DEPTH means almostfull is never asserted. af_thresh = 0 means almostfull is always asserted.
- FWFT=0: on rd_acc, data_out <= mem[rd_ptr] and valid <= 1; otherwise valid <= 0 and data_out holds. Read latency is 1 cycle.
- FWFT=1: data_out = mem[rd_ptr] combinationally and valid = !empty. rd_en acknowledges the displayed word. A written word is visible the cycle after wr_acc.
- A write to a full FIFO with no read leaves memory and wr_ptr unchanged.

Decomposition:
- Package fifo_pkg holds the helper function for pointer width and the shared localparams for flag encodings, reused by later FIFO variants.
- Sub-module fifo_mem_2p is the natural split. It holds the DEPTH x DATA_W storage with one synchronous write port and one asynchronous read port.
- Control, counters, flags and output registers stay in sync_fifo_prog.

Test Plan:
- Reset then idle (DEPTH=8) -> count=0, empty=1, almostempty=1, full=0, all pulses and stickies 0.
- Write 8 words 0x0001..0x0008, then a 9th write -> wr_ack high for 8 cycles. On the 9th, overflow=1 and ovf_sticky=1; count stays 8 and full=1.
- From full, wr_en=rd_en=1 for 4 cycles with new data 0x00A0..0x00A3 -> count stays 8 and no overflow. With FWFT=0, outputs 0x0001..0x0004 appear one cycle after each read; later reads return 0x0005..0x0008 then 0x00A0..0x00A3.
- From empty, rd_en=1 -> underflow=1 and unf_sticky=1. Assert err_clr -> unf_sticky=0 the next cycle. With wr_en=rd_en=1 while empty -> count=1 and underflow=1.
- Thresholds af_thresh=6, ae_thresh=2: fill from 0 to 8 -> almostempty high for count 0..2 and almostfull high for count 6..8. With af_thresh=9 -> almostfull never asserts.
- Fill 5 words with FWFT=1 and pulse rst_n low mid-burst -> the next cycle count=0, valid=0, empty=1, and both pointers restart at 0 (next writes and reads start from mem[0]).

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the synchronous FIFO family.
//   ptr_w()          - pointer width for a given entry count
//   ERR_OVF/ERR_UNF  - bit positions of the error flags in error vectors
package fifo_pkg;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_W   = 2;

    // Minimum of one bit so a degenerate depth still gives a legal vector.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: DEPTH x DATA_W storage, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk      - write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data (combinational from raddr_i)
module fifo_mem_2p #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable almost-full/empty
// thresholds, occupancy output and sticky error flags.
//   clk, rst_n            - clock, synchronous active-low reset
//   wr_en, data_in        - write request and data
//   rd_en                 - read request (pop)
//   af_thresh, ae_thresh  - live almost-full / almost-empty thresholds
//   err_clr               - clears the sticky error flags
//   data_out, valid       - read data and qualifier (registered or FWFT)
//   wr_ack/overflow/underflow - one-cycle registered outcome pulses
//   full/empty/almostfull/almostempty - decoded from registered count
//   count                 - occupancy 0..DEPTH
//   ovf_sticky/unf_sticky - latched error flags
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = ptr_w(DEPTH),
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   af_thresh,
    input  logic [ADDR_W:0]   ae_thresh,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              wr_ack,
    output logic              overflow,
    output logic              underflow,
    output logic              full,
    output logic              empty,
    output logic              almostfull,
    output logic              almostempty,
    output logic [ADDR_W:0]   count,
    output logic              ovf_sticky,
    output logic              unf_sticky
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wr_ack_q;
    logic [ERR_W-1:0]  err_now, err_pulse_q, err_sticky_q;
    logic              rd_acc, wr_acc;
    logic [DATA_W-1:0] mem_rdata;

    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= af_thresh);
    assign almostempty = (count_q <= ae_thresh);
    assign count       = count_q;

    // A write into a full FIFO is only taken when a read frees a slot
    // in the same cycle.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        err_now          = '0;
        err_now[ERR_OVF] = wr_en && !wr_acc;
        err_now[ERR_UNF] = rd_en && !rd_acc;
    end

    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
        else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wr_ack_q     <= 1'b0;
            err_pulse_q  <= '0;
            err_sticky_q <= '0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            count_q      <= count_d;
            wr_ack_q     <= wr_acc;
            err_pulse_q  <= err_now;
            // New error wins over a coincident clear.
            err_sticky_q <= (err_sticky_q & {ERR_W{!err_clr}}) | err_now;
        end
    end

    assign wr_ack     = wr_ack_q;
    assign overflow   = err_pulse_q[ERR_OVF];
    assign underflow  = err_pulse_q[ERR_UNF];
    assign ovf_sticky = err_sticky_q[ERR_OVF];
    assign unf_sticky = err_sticky_q[ERR_UNF];

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always on display; rd_en just acknowledges it.
            assign data_out = mem_rdata;
            assign valid    = !empty;
        end else begin : g_reg
            logic [DATA_W-1:0] dout_q;
            logic              vld_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= rd_acc;
                    if (rd_acc) dout_q <= mem_rdata;
                end
            end
            assign data_out = dout_q;
            assign valid    = vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
module tb_sync_fifo_prog;

    localparam int DW = 16;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [AW:0]   af_thresh = 4'd6, ae_thresh = 4'd2;

    // FWFT=0 instance
    logic [DW-1:0] data_out0;
    logic valid0, wr_ack0, overflow0, underflow0, full0, empty0;
    logic almostfull0, almostempty0, ovf_sticky0, unf_sticky0;
    logic [AW:0] count0;
    // FWFT=1 instance
    logic [DW-1:0] data_out1;
    logic valid1, wr_ack1, overflow1, underflow1, full1, empty1;
    logic almostfull1, almostempty1, ovf_sticky1, unf_sticky1;
    logic [AW:0] count1;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_W(DW), .DEPTH(D), .FWFT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
        .data_out(data_out0), .valid(valid0), .wr_ack(wr_ack0), .overflow(overflow0),
        .underflow(underflow0), .full(full0), .empty(empty0), .almostfull(almostfull0),
        .almostempty(almostempty0), .count(count0), .ovf_sticky(ovf_sticky0),
        .unf_sticky(unf_sticky0));

    sync_fifo_prog #(.DATA_W(DW), .DEPTH(D), .FWFT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
        .data_out(data_out1), .valid(valid1), .wr_ack(wr_ack1), .overflow(overflow1),
        .underflow(underflow1), .full(full1), .empty(empty1), .almostfull(almostfull1),
        .almostempty(almostempty1), .count(count1), .ovf_sticky(ovf_sticky1),
        .unf_sticky(unf_sticky1));

    typedef struct {
        logic          w, r, c;
        logic [DW-1:0] d;
        logic [AW:0]   cnt;
        logic [8:0]    fl;   // {full,empty,af,ae,wr_ack,ovf,unf,ovs,uns}
    } vec_t;

    vec_t          tbl[$];
    logic [DW-1:0] mq[$];    // model FIFO contents
    logic [DW-1:0] exq[$];   // expected registered-read outputs
    int            n_vec = 0, n_err = 0;

    function automatic logic [8:0] flags0();
        return {full0, empty0, almostfull0, almostempty0, wr_ack0,
                overflow0, underflow0, ovf_sticky0, unf_sticky0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic r, input logic [DW-1:0] d,
                       input logic c, input logic [AW:0] cnt, input logic [8:0] fl);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.c = c; v.cnt = cnt; v.fl = fl;
        tbl.push_back(v);
    endtask

    // One clock of stimulus; the model predicts acceptance and the
    // scoreboard checks the FWFT=0 read data one cycle later.
    task automatic drive(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        logic m_rd, m_wr;
        @(negedge clk);
        wr_en = w; rd_en = r; data_in = d; err_clr = c;
        m_rd = r && (mq.size() > 0);
        m_wr = w && ((mq.size() < D) || m_rd);
        if (m_rd) exq.push_back(mq.pop_front());
        if (m_wr) mq.push_back(d);
        @(posedge clk); #1;
        chk("valid0", valid0, m_rd);
        if (m_rd && exq.size() > 0) chk("data0", data_out0, exq.pop_front());
    endtask

    task automatic do_reset(input logic w);
        @(negedge clk);
        rst_n = 1'b0; wr_en = w; rd_en = 1'b0; err_clr = 1'b0; data_in = 16'hDEAD;
        @(posedge clk); #1;
        mq.delete(); exq.delete();
        @(negedge clk);
        rst_n = 1'b1; wr_en = 1'b0;
    endtask

    initial begin
        // Main vector table (af_thresh=6, ae_thresh=2)
        add(0, 0, 16'h0, 0, 4'd0, 9'b0_1_0_1_0_0_0_0_0);
        for (int k = 1; k <= 8; k++)
            add(1, 0, 16'(k), 0, 4'(k), {k == 8, 1'b0, k >= 6, k <= 2, 1'b1, 4'b0});
        add(1, 0, 16'h0099, 0, 4'd8, 9'b1_0_1_0_0_1_0_1_0);
        for (int k = 0; k < 4; k++)
            add(1, 1, 16'h00A0 + 16'(k), 0, 4'd8, 9'b1_0_1_0_1_0_0_1_0);
        add(0, 0, 16'h0, 1, 4'd8, 9'b1_0_1_0_0_0_0_0_0);
        for (int k = 7; k >= 0; k--)
            add(0, 1, 16'h0, 0, 4'(k), {1'b0, k == 0, k >= 6, k <= 2, 5'b0});
        add(0, 1, 16'h0, 0, 4'd0, 9'b0_1_0_1_0_0_1_0_1);
        add(0, 0, 16'h0, 0, 4'd0, 9'b0_1_0_1_0_0_0_0_1);
        add(0, 0, 16'h0, 1, 4'd0, 9'b0_1_0_1_0_0_0_0_0);
        add(1, 1, 16'h0055, 0, 4'd1, 9'b0_0_0_1_1_0_1_0_1);
        add(0, 1, 16'h0, 0, 4'd0, 9'b0_1_0_1_0_0_0_0_1);
        add(0, 1, 16'h0, 1, 4'd0, 9'b0_1_0_1_0_0_1_0_1);
        add(0, 0, 16'h0, 1, 4'd0, 9'b0_1_0_1_0_0_0_0_0);

        do_reset(1'b0);
        chk("rst_count0", count0, 0);
        chk("rst_flags0", flags0(), 9'b0_1_0_1_0_0_0_0_0);
        chk("rst_valid0", valid0, 0);
        chk("rst_dout0", data_out0, 0);
        chk("rst_valid1", valid1, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].w, tbl[i].r, tbl[i].d, tbl[i].c);
            chk($sformatf("count[%0d]", i), count0, tbl[i].cnt);
            chk($sformatf("flags[%0d]", i), flags0(), tbl[i].fl);
        end

        // af_thresh above DEPTH: almostfull never asserts
        af_thresh = 4'd9;
        do_reset(1'b0);
        for (int k = 1; k <= 8; k++) begin
            drive(1, 0, 16'h0100 + 16'(k), 0);
            chk($sformatf("af9[%0d]", k), almostfull0, 0);
        end
        chk("af9_full", full0, 1);

        // af_thresh=0 always asserted; ae_thresh=0 still almostempty at reset
        af_thresh = 4'd0; ae_thresh = 4'd0;
        do_reset(1'b0);
        chk("af0_empty", almostfull0, 1);
        chk("ae0_empty", almostempty0, 1);
        drive(1, 0, 16'h0200, 0);
        chk("ae0_cnt1", almostempty0, 0);
        af_thresh = 4'd6; ae_thresh = 4'd2;

        // FWFT: fill 5, reset mid-burst, pointers restart at 0
        do_reset(1'b0);
        drive(1, 0, 16'h0011, 0);
        chk("fwft_valid", valid1, 1);
        chk("fwft_head", data_out1, 16'h0011);
        for (int k = 2; k <= 5; k++) drive(1, 0, 16'h0010 + 16'(k), 0);
        chk("fwft_cnt5", count1, 5);
        chk("fwft_head5", data_out1, 16'h0011);
        do_reset(1'b1);
        chk("mid_rst_cnt", count1, 0);
        chk("mid_rst_valid1", valid1, 0);
        chk("mid_rst_empty", empty1, 1);
        chk("mid_rst_valid0", valid0, 0);
        drive(1, 0, 16'h00B0, 0);
        chk("restart_head", data_out1, 16'h00B0);
        chk("restart_valid", valid1, 1);
        drive(1, 1, 16'h00B1, 0);
        chk("restart_head2", data_out1, 16'h00B1);
        chk("restart_cnt", count1, 1);
        drive(0, 1, 16'h0, 0);
        chk("drain_valid1", valid1, 0);
        chk("drain_cnt", count1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
